// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_UPPER, S_ALUWB, S_BRANCH, S_JAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // ALU operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format is a pure function of the opcode
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALU op class plus funct fields to ALUControl.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  // funct decode only when the FSM asks for it; op5 separates R-type from I-type
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: main FSM, ImmSrc decode and ALU decode.
// Every output is forced to 0 while rst_n is low so a reset mid-instruction
// cannot leak a write after the reset edge.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IllegalInstr
);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_imm;
  logic [1:0] w_alu_op;
  logic [2:0] w_alu_control;
  logic [1:0] w_srca;
  logic [1:0] w_srcb;
  logic [1:0] w_res;
  logic       w_adr;
  logic       w_irw;
  logic       w_pcw;
  logic       w_rw;
  logic       w_mw;
  logic       w_ill;
  logic       w_taken;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RESET_STATE;
    else        r_state <= w_next;
  end

  assign w_taken = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);

  // Next-state and datapath controls for the current state
  always_comb begin
    w_next   = r_state;
    w_imm    = imm_src(op);
    w_alu_op = ALUOP_ADD;
    w_srca   = SRCA_PC;
    w_srcb   = SRCB_RD2;
    w_res    = RES_ALUOUT;
    w_adr    = 1'b0;
    w_irw    = 1'b0;
    w_pcw    = 1'b0;
    w_rw     = 1'b0;
    w_mw     = 1'b0;
    w_ill    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_srcb = SRCB_FOUR;
        w_res  = RES_ALURESULT;
        if (MemReady) begin
          w_irw  = 1'b1;
          w_pcw  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures OldPC + imm as the branch/jump target
        w_srca = SRCA_OLDPC;
        w_srcb = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_LUI, OP_AUIPC:  w_next = S_UPPER;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default: begin
            w_ill  = 1'b1;
            w_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_srca = SRCA_RD1;
        w_srcb = SRCB_IMM;
        w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr = 1'b1;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res  = RES_DATA;
        w_rw   = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr = 1'b1;
        w_mw  = 1'b1;
        if (MemReady) w_next = S_FETCH;
      end
      S_EXECUTER: begin
        w_srca   = SRCA_RD1;
        w_srcb   = SRCB_RD2;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_srca   = SRCA_RD1;
        w_srcb   = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_UPPER: begin
        // lui adds the immediate to zero, auipc to OldPC
        w_srca = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        w_srcb = SRCB_IMM;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_srca   = SRCA_RD1;
        w_srcb   = SRCB_RD2;
        w_alu_op = ALUOP_SUB;
        w_pcw    = w_taken;
        w_next   = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd
        w_srca = SRCA_OLDPC;
        w_srcb = SRCB_FOUR;
        w_pcw  = 1'b1;
        w_next = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (op[5]),
    .o_alu_control (w_alu_control)
  );

  assign ImmSrc       = rst_n ? w_imm         : 3'b000;
  assign ALUControl   = rst_n ? w_alu_control : 3'b000;
  assign ALUSrcA      = rst_n ? w_srca        : 2'b00;
  assign ALUSrcB      = rst_n ? w_srcb        : 2'b00;
  assign ResultSrc    = rst_n ? w_res         : 2'b00;
  assign AdrSrc       = rst_n & w_adr;
  assign IRWrite      = rst_n & w_irw;
  assign PCWrite      = rst_n & w_pcw;
  assign RegWrite     = rst_n & w_rw;
  assign MemWrite     = rst_n & w_mw;
  assign IllegalInstr = rst_n & w_ill;

endmodule
